// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bursts of up to BURST_LEN words.
// Define FIFO_ARB_STATS_EN to add saturating stall_cnt / grant_cnt counters.
module fifo_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     full,
  output logic                     write,
  output logic [WIDTH-1:0]         data_in,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              grant_cnt
`endif
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [0:0]    state;
  logic [GW-1:0] g;
  logic [GW-1:0] rr_ptr;
  logic [BW-1:0] beat;

  logic [GW-1:0] next_ptr;
  logic [GW-1:0] search_base;
  logic [GW-1:0] pick;
  logic          pick_valid;
  logic          in_grant;
  logic          accept;
  logic          burst_end;
  logic          start_burst;
  int            idx;

  always_comb begin
    in_grant    = (state == GRANT) && !reset;
    accept      = in_grant && req[g] && !full;
    ack         = '0;
    if (accept) ack[g] = 1'b1;
    write       = accept;
    data_in     = in_grant ? wdata[int'(g)*WIDTH +: WIDTH] : '0;
    busy        = in_grant;
    next_ptr    = (g == GW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    // A burst closes on the ack that fills it, or when the granted producer lets go.
    burst_end   = (state == GRANT) && (!req[g] || (accept && beat == BW'(BURST_LEN - 1)));
    search_base = (state == GRANT) ? next_ptr : rr_ptr;
    pick        = '0;
    pick_valid  = 1'b0;
    idx         = 0;
    // Scan offsets from farthest to nearest so the nearest requester wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(search_base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pick       = GW'(idx);
        pick_valid = 1'b1;
      end
    end
    start_burst = !reset && pick_valid && ((state == IDLE) || burst_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      g      <= '0;
      gnt    <= '0;
      rr_ptr <= '0;
      beat   <= '0;
    end else begin
      if (start_burst) begin
        state <= GRANT;
        g     <= pick;
        gnt   <= ONE << pick;
        beat  <= '0;
      end else if (burst_end) begin
        state <= IDLE;
        gnt   <= '0;
        beat  <= '0;
      end else if (accept) begin
        beat <= beat + 1'b1;
      end
      if (burst_end) rr_ptr <= next_ptr;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if ((state == GRANT) && req[g] && full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (start_burst && (grant_cnt != 16'hFFFF))
        grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: queue-based producers, a round-robin reference model
// compared every cycle, and literal expectations for each scenario.
module tb_fifo_write_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic           full = 1'b0;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           write;
  logic [W-1:0]   data_in;
  logic           busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    stall_cnt;
  logic [15:0]    grant_cnt;
`endif

  // clock / reset
  always #5 clk = ~clk;

  fifo_write_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(B)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack), .gnt(gnt),
    .full(full), .write(write), .data_in(data_in), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // producers: each holds a list of words, req high while words remain
  logic [W-1:0] pdata [N][16];
  int           phead [N];
  int           plen  [N];
  logic [N-1:0] ack_s = '0;

  task automatic load(input int p, input logic [W-1:0] v);
    pdata[p][plen[p]] = v;
    plen[p]++;
  endtask

  task automatic clear_prod();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      plen[i]  = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (phead[i] < plen[i]) begin
        req[i] = 1'b1;
        wdata[i*W +: W] = pdata[i][phead[i]];
      end else begin
        req[i] = 1'b0;
        wdata[i*W +: W] = '0;
      end
    end
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (phead[i] < plen[i]) r = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ack_s[i] === 1'b1 && phead[i] < plen[i]) phead[i]++;
    drive();
    #1;
  endtask

  // reference model: who holds the grant, words taken in this burst, rotation pointer
  bit started = 1'b0;
  int m_busy = 0, m_g = 0, m_cnt = 0, m_ptr = 0, m_stall = 0, m_gcnt = 0;

  function automatic void m_pick(input int base);
    bit found = 1'b0;
    m_busy = 0;
    for (int k = 0; k < N; k++) begin
      int i = (base + k) % N;
      if (!found && req[i]) begin
        found  = 1'b1;
        m_busy = 1;
        m_g    = i;
        m_cnt  = 0;
        if (m_gcnt < 65535) m_gcnt++;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_stall = 0; m_gcnt = 0;
    end else if (started) begin
      if (m_busy != 0) begin
        if (req[m_g] && full && m_stall < 65535) m_stall++;
        if (req[m_g] && !full) m_cnt++;
        if (!req[m_g] || m_cnt == B) begin
          m_ptr = (m_g + 1) % N;
          m_pick(m_ptr);
        end
      end else begin
        m_pick(m_ptr);
      end
    end
  end

  // scoreboard and per-cycle compare
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_log[$];
  int           wr_cyc[$];
  logic [N-1:0] gnt_log[$];
  logic [N-1:0] last_gnt = '0;
  int           cyc = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_ack;
    logic [W-1:0] e_data;
    logic         e_act, e_wr;
    ack_s = ack;
    if (write === 1'b1) begin
      wr_log.push_back(data_in);
      wr_cyc.push_back(cyc);
    end
    if (gnt !== last_gnt && gnt !== '0) gnt_log.push_back(gnt);
    last_gnt = gnt;
    cyc++;
    if (started) begin
      e_gnt  = (m_busy != 0) ? N'(1 << m_g) : '0;
      e_act  = (m_busy != 0) && !reset;
      e_wr   = e_act && req[m_g] && !full;
      e_ack  = e_wr ? e_gnt : '0;
      e_data = e_act ? wdata[m_g*W +: W] : '0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("write", 32'(write), 32'(e_wr));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("data_in", 32'(data_in), 32'(e_data));
      chk("busy", 32'(busy), 32'(e_act));
`ifdef FIFO_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("grant_cnt", 32'(grant_cnt), 32'(m_gcnt));
`endif
      if (e_wr) exp_q.push_back(e_data);
      if (write === 1'b1) begin
        if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(1), 32'(0));
        else chk("sb_word", 32'(data_in), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    full  = 1'b0;
    clear_prod();
    drive();
    repeat (n) tick();
    wr_log.delete();
    wr_cyc.delete();
    gnt_log.delete();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy !== 1'b0 || pending()) && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_within_budget", 32'(n < maxc), 32'(1));
  endtask

  logic [W-1:0] t1_exp [6] = '{8'h07, 8'h27, 8'h37, 8'h97, 8'hA1, 8'hA2};
  logic [N-1:0] t2_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with every producer requesting
    clear_prod();
    for (int i = 0; i < N; i++) load(i, 8'hE0 + 8'(i));
    drive();
    repeat (2) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_write", 32'(write), 32'(0));
      chk("rst_ack", 32'(ack), 32'(0));
      chk("rst_data", 32'(data_in), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
    end
    do_reset(1);

    // single producer, six words: burst of four then back-to-back regrant
    for (int j = 0; j < 6; j++) load(0, t1_exp[j]);
    drive();
    tick();
    chk("t1_gnt_first", 32'(gnt), 32'(4'b0001));
    chk("t1_data_first", 32'(data_in), 32'(8'h07));
    wait_idle(40);
    chk("t1_nwords", 32'(wr_log.size()), 32'(6));
    for (int j = 0; j < 6; j++)
      if (j < wr_log.size()) chk("t1_word", 32'(wr_log[j]), 32'(t1_exp[j]));
    if (wr_cyc.size() == 6) chk("t1_no_bubble", 32'(wr_cyc[5] - wr_cyc[0]), 32'(5));
    chk("t1_gnt_changes", 32'(gnt_log.size()), 32'(1));

    // all producers requesting: rotation 0,1,2,3,0 with no idle cycles
    do_reset(1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) load(i, 8'(i * 16 + j));
    drive();
    wait_idle(100);
    chk("t2_nwords", 32'(wr_log.size()), 32'(32));
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) chk("t2_gnt_seq", 32'(gnt_log[k]), 32'(t2_gnt[k]));
    if (wr_log.size() == 32) begin
      chk("t2_word4", 32'(wr_log[4]), 32'(8'h10));
      chk("t2_word16", 32'(wr_log[16]), 32'(8'h04));
      chk("t2_contiguous", 32'(wr_cyc[31] - wr_cyc[0]), 32'(31));
    end

    // full back-pressure on producer 1
    do_reset(1);
    for (int j = 0; j < 4; j++) load(1, 8'h51 + 8'(j));
    drive();
    tick();
    chk("t3_gnt", 32'(gnt), 32'(4'b0010));
    chk("t3_first", 32'(data_in), 32'(8'h51));
    tick();
    full = 1'b1;
    #1;
    repeat (3) begin
      chk("t3_full_write", 32'(write), 32'(0));
      chk("t3_full_ack", 32'(ack), 32'(0));
      chk("t3_full_gnt", 32'(gnt), 32'(4'b0010));
      tick();
    end
    full = 1'b0;
    #1;
    chk("t3_resume_write", 32'(write), 32'(1));
    chk("t3_resume_data", 32'(data_in), 32'(8'h52));
    wait_idle(20);
    chk("t3_nwords", 32'(wr_log.size()), 32'(4));
    chk("t3_one_grant", 32'(gnt_log.size()), 32'(1));
`ifdef FIFO_ARB_STATS_EN
    chk("t3_stall_cnt", 32'(stall_cnt), 32'(3));
    chk("t3_grant_cnt", 32'(grant_cnt), 32'(1));
`endif

    // early release by producer 2 with producer 3 waiting
    do_reset(1);
    load(2, 8'h2A); load(2, 8'h2B);
    load(3, 8'h3A); load(3, 8'h3B); load(3, 8'h3C);
    drive();
    tick();
    chk("t4_gnt2", 32'(gnt), 32'(4'b0100));
    chk("t4_data2a", 32'(data_in), 32'(8'h2A));
    tick();
    chk("t4_data2b", 32'(data_in), 32'(8'h2B));
    tick();
    chk("t4_drop_write", 32'(write), 32'(0));
    chk("t4_drop_gnt", 32'(gnt), 32'(4'b0100));
    tick();
    chk("t4_gnt3", 32'(gnt), 32'(4'b1000));
    chk("t4_data3a", 32'(data_in), 32'(8'h3A));
    wait_idle(20);
    chk("t4_nwords", 32'(wr_log.size()), 32'(5));

    // reset mid-burst after two words
    do_reset(1);
    for (int j = 0; j < 4; j++) load(0, 8'hC0 + 8'(j));
    drive();
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_write", 32'(write), 32'(0));
    chk("t5_rst_ack", 32'(ack), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    chk("t5_rst_data", 32'(data_in), 32'(0));
    chk("t5_gnt_held", 32'(gnt), 32'(4'b0001));
    tick();
    chk("t5_gnt_cleared", 32'(gnt), 32'(0));
    chk("t5_nwords", 32'(wr_log.size()), 32'(2));
`ifdef FIFO_ARB_STATS_EN
    chk("t5_stall_cnt", 32'(stall_cnt), 32'(0));
    chk("t5_grant_cnt", 32'(grant_cnt), 32'(0));
`endif
    clear_prod();
    drive();
    reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
